// File: rtl/video_pkg.sv
// Shared video-path types: highlight modes, pixel struct, coordinate widths.
package video_pkg;

  localparam logic [1:0] MODE_G    = 2'b00;
  localparam logic [1:0] MODE_R    = 2'b01;
  localparam logic [1:0] MODE_B    = 2'b10;
  localparam logic [1:0] MODE_PASS = 2'b11;

  localparam int XW = 10;
  localparam int YW = 9;
  localparam int CW = 19;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic logic is_gray(input rgb_t p);
    return (p.r == p.g) && (p.g == p.b);
  endfunction

endpackage

// File: rtl/bbox_accum.sv
// Per-frame min/max/count of colored pixel positions.
// init restarts the frame; with update it seeds from the current pixel.
module bbox_accum
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  input  logic          update,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [XW-1:0] xmin,
  output logic [XW-1:0] xmax,
  output logic [YW-1:0] ymin,
  output logic [YW-1:0] ymax,
  output logic [CW-1:0] cnt
);

  localparam logic [XW-1:0] XLAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] YLAST = YW'(V_ACTIVE - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xmin <= XLAST;
      xmax <= '0;
      ymin <= YLAST;
      ymax <= '0;
      cnt  <= '0;
    end else if (init) begin
      if (update) begin
        xmin <= x;
        xmax <= x;
        ymin <= y;
        ymax <= y;
        cnt  <= CW'(1);
      end else begin
        xmin <= XLAST;
        xmax <= '0;
        ymin <= YLAST;
        ymax <= '0;
        cnt  <= '0;
      end
    end else if (update) begin
      if (x < xmin) xmin <= x;
      if (x > xmax) xmax <= x;
      if (y < ymin) ymin <= y;
      if (y > ymax) ymax <= y;
      if (cnt != '1) cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/color_bbox_tracker.sv
// Bounding box of non-gray pixels per frame, outlined into the next frame.
// Position counters, frame-close latch and overlay mux; 1-cycle latency.
module color_bbox_tracker
  import video_pkg::*;
#(
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter int          MIN_COUNT = 64,
  parameter logic [23:0] BOX_RGB   = 24'hFFFF00
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic          in_eol,
  input  logic [7:0]    in_r,
  input  logic [7:0]    in_g,
  input  logic [7:0]    in_b,
  input  logic [1:0]    mode,
  output logic          out_valid,
  output logic          out_sof,
  output logic          out_eol,
  output logic [7:0]    out_r,
  output logic [7:0]    out_g,
  output logic [7:0]    out_b,
  output logic          box_valid,
  output logic [XW-1:0] box_xmin,
  output logic [XW-1:0] box_xmax,
  output logic [YW-1:0] box_ymin,
  output logic [YW-1:0] box_ymax,
  output logic [CW-1:0] pix_count
);

  localparam logic [XW-1:0] XLAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] YLAST = YW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] MINC  = CW'(MIN_COUNT);

  rgb_t          pix;
  rgb_t          out_pix;
  logic [XW-1:0] x, cx;
  logic [YW-1:0] y, cy;
  logic          frame_close;
  logic          colored;
  logic [XW-1:0] acc_xmin, acc_xmax;
  logic [YW-1:0] acc_ymin, acc_ymax;
  logic [CW-1:0] acc_cnt;
  logic          acc_ok;
  logic          ov_valid;
  logic [XW-1:0] ov_xmin, ov_xmax;
  logic [YW-1:0] ov_ymin, ov_ymax;
  logic          on_col, on_row, on_box;

  assign pix         = '{r: in_r, g: in_g, b: in_b};
  assign cx          = in_sof ? '0 : x;
  assign cy          = in_sof ? '0 : y;
  assign frame_close = in_valid && in_sof;
  assign colored     = in_valid && (mode != MODE_PASS)
                       && !is_gray(pix);
  assign acc_ok      = acc_cnt >= MINC;

  bbox_accum #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_accum (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (frame_close),
    .update (colored),
    .x      (cx),
    .y      (cy),
    .xmin   (acc_xmin),
    .xmax   (acc_xmax),
    .ymin   (acc_ymin),
    .ymax   (acc_ymax),
    .cnt    (acc_cnt)
  );

  // sof pixel already belongs to the new frame, so it sees the box being latched
  always_comb begin
    ov_valid = box_valid;
    ov_xmin  = box_xmin;
    ov_xmax  = box_xmax;
    ov_ymin  = box_ymin;
    ov_ymax  = box_ymax;
    if (in_sof) begin
      ov_valid = acc_ok;
      ov_xmin  = acc_xmin;
      ov_xmax  = acc_xmax;
      ov_ymin  = acc_ymin;
      ov_ymax  = acc_ymax;
    end
    on_col = ((cx == ov_xmin) || (cx == ov_xmax))
             && (cy >= ov_ymin) && (cy <= ov_ymax);
    on_row = ((cy == ov_ymin) || (cy == ov_ymax))
             && (cx >= ov_xmin) && (cx <= ov_xmax);
    on_box = ov_valid && (on_col || on_row);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (in_valid) begin
      if (in_eol) begin
        x <= '0;
        y <= (cy == YLAST) ? YLAST : cy + YW'(1);
      end else begin
        x <= (cx == XLAST) ? XLAST : cx + XW'(1);
        y <= cy;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_valid <= 1'b0;
      box_xmin  <= '0;
      box_xmax  <= '0;
      box_ymin  <= '0;
      box_ymax  <= '0;
      pix_count <= '0;
    end else if (frame_close) begin
      box_valid <= acc_ok;
      box_xmin  <= acc_xmin;
      box_xmax  <= acc_xmax;
      box_ymin  <= acc_ymin;
      box_ymax  <= acc_ymax;
      pix_count <= acc_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_pix   <= '0;
    end else begin
      out_valid <= in_valid;
      out_sof   <= in_valid && in_sof;
      out_eol   <= in_valid && in_eol;
      if (in_valid) out_pix <= on_box ? rgb_t'(BOX_RGB) : pix;
    end
  end

  assign out_r = out_pix.r;
  assign out_g = out_pix.g;
  assign out_b = out_pix.b;

endmodule
